otter_control_unit: RTL

//  Multi-cycle RV32I control unit: sequences FETCH/EXEC/WRITEBACK and decodes IR into datapath selects.

---
 rtl/otter_ctrl_pkg.sv | 72 +++++++
 rtl/otter_decoder.sv | 98 +++++++++
 rtl/otter_control_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/otter_ctrl_pkg.sv
// Shared types and encodings for the OTTER multi-cycle control unit.
// The optional interrupt/CSR support is controlled by the CU_INTR_EN macro.
package otter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } state_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_COPY = 4'b1001;

  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_UIMM = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_PC   = 2'd3;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  localparam logic [1:0] RF_PC4 = 2'd0;
  localparam logic [1:0] RF_CSR = 2'd1;
  localparam logic [1:0] RF_MEM = 2'd2;
  localparam logic [1:0] RF_ALU = 2'd3;

  // funct3 010/011 are not branch conditions and resolve to not-taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_decoder.sv
// Combinational instruction decoder: ir and branch flags -> ALU op, datapath selects, class flags.
// CSR/mret decoding exists only when CU_INTR_EN is defined; otherwise SYSTEM is a NOP.
module otter_decoder
  import otter_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic [3:0]  alu_fun,
  output logic        srcA_sel,
  output logic [1:0]  srcB_sel,
  output logic [2:0]  pc_sel,
  output logic [1:0]  rf_wr_sel,
  output logic        rf_write,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal
);

  logic [2:0] funct3;
  opcode_t    opcode;
  logic       unused_ir;

  assign funct3    = ir[14:12];
  assign opcode    = opcode_t'(ir[6:0]);
  assign unused_ir = ^ir;

  always_comb begin
    alu_fun   = ALU_ADD;
    srcA_sel  = SRCA_RS1;
    srcB_sel  = SRCB_RS2;
    pc_sel    = PC_PLUS4;
    rf_wr_sel = RF_PC4;
    rf_write  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_REG: begin
        alu_fun   = {ir[30], funct3};
        rf_wr_sel = RF_ALU;
        rf_write  = 1'b1;
      end
      OP_IMM: begin
        // ir[30] only distinguishes srai from srli; for other immediates it is imm data
        alu_fun   = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
        srcB_sel  = SRCB_IIMM;
        rf_wr_sel = RF_ALU;
        rf_write  = 1'b1;
      end
      OP_LUI: begin
        alu_fun   = ALU_COPY;
        srcA_sel  = SRCA_UIMM;
        rf_wr_sel = RF_ALU;
        rf_write  = 1'b1;
      end
      OP_AUIPC: begin
        srcA_sel  = SRCA_UIMM;
        srcB_sel  = SRCB_PC;
        rf_wr_sel = RF_ALU;
        rf_write  = 1'b1;
      end
      OP_LOAD: begin
        srcB_sel  = SRCB_IIMM;
        rf_wr_sel = RF_MEM;
        is_load   = 1'b1;
      end
      OP_STORE: begin
        srcB_sel = SRCB_SIMM;
        is_store = 1'b1;
      end
      OP_JAL: begin
        pc_sel   = PC_JAL;
        rf_write = 1'b1;
      end
      OP_JALR: begin
        pc_sel   = PC_JALR;
        rf_write = 1'b1;
      end
      OP_BRANCH: begin
        pc_sel = branch_taken(funct3, br_eq, br_lt, br_ltu) ? PC_BRANCH : PC_PLUS4;
      end
      OP_SYSTEM: begin
`ifdef CU_INTR_EN
        if (funct3 == 3'b000) begin
          if (ir[29:28] == 2'b11) pc_sel = PC_MEPC;
        end else begin
          rf_wr_sel = RF_CSR;
          rf_write  = 1'b1;
        end
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/EXEC/WB sequencing plus strobe generation.
// Define CU_INTR_EN to enable interrupt entry (ST_INTR), mret and CSR writeback.
module otter_control_unit
  import otter_ctrl_pkg::*;
#(
  parameter int RESET_STATE_INIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        intr,
  output logic [3:0]  alu_fun,
  output logic        srcA_sel,
  output logic [1:0]  srcB_sel,
  output logic [2:0]  pc_sel,
  output logic [1:0]  rf_wr_sel,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic        int_taken,
  output logic        illegal_op
);

  localparam state_t RESET_STATE = (RESET_STATE_INIT != 0) ? ST_INIT : ST_FETCH;

  state_t     state_reg, state_next;
  logic [3:0] dec_alu_fun;
  logic       dec_srcA_sel;
  logic [1:0] dec_srcB_sel;
  logic [2:0] dec_pc_sel;
  logic [1:0] dec_rf_wr_sel;
  logic       dec_rf_write, dec_is_load, dec_is_store, dec_illegal;
  logic       intr_go;

`ifdef CU_INTR_EN
  assign intr_go = intr;
`else
  logic unused_intr;
  assign unused_intr = intr;
  assign intr_go     = 1'b0;
`endif

  otter_decoder u_decoder (
    .ir        (ir),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .br_ltu    (br_ltu),
    .alu_fun   (dec_alu_fun),
    .srcA_sel  (dec_srcA_sel),
    .srcB_sel  (dec_srcB_sel),
    .pc_sel    (dec_pc_sel),
    .rf_wr_sel (dec_rf_wr_sel),
    .rf_write  (dec_rf_write),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RESET_STATE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    alu_fun    = ALU_ADD;
    srcA_sel   = SRCA_RS1;
    srcB_sel   = SRCB_RS2;
    pc_sel     = PC_PLUS4;
    rf_wr_sel  = RF_PC4;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    int_taken  = 1'b0;
    illegal_op = 1'b0;
    // Decode drives the datapath only in EXEC/WB, so reset and fetch present all-zero selects.
    if (state_reg == ST_EXEC || state_reg == ST_WB) begin
      alu_fun   = dec_alu_fun;
      srcA_sel  = dec_srcA_sel;
      srcB_sel  = dec_srcB_sel;
      pc_sel    = dec_pc_sel;
      rf_wr_sel = dec_rf_wr_sel;
    end
    case (state_reg)
      ST_INIT: state_next = ST_FETCH;
      ST_FETCH: begin
        mem_rden1  = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        pc_write   = 1'b1;
        illegal_op = dec_illegal;
        if (dec_is_load) begin
          mem_rden2  = 1'b1;
          state_next = ST_WB;
        end else begin
          reg_write  = dec_rf_write;
          mem_we2    = dec_is_store;
          state_next = intr_go ? ST_INTR : ST_FETCH;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        state_next = intr_go ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
`ifdef CU_INTR_EN
        pc_sel    = PC_MTVEC;
        pc_write  = 1'b1;
        int_taken = 1'b1;
`endif
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule
